fuzz_sig_sched: RTL

- Run controller for one generated fuzz DUT in the Yosys bug-hunt flow.
- Sequences a stimulus run: loads a seed, drives pseudo-random values onto the DUT input bus, and compacts the DUT's wide output bus into a signature with a MISR.
- Compares the signature against an expected value so synthesised and RTL netlists can be checked against each other cycle-exactly.
- Sits between the bench/host handshake and the DUT's flattened input and output buses.

---
 rtl/fuzz_sig_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/fuzz_sig_sched.sv
// Run controller for one generated fuzz DUT: seeds an LFSR onto the DUT input bus and
// compacts the DUT output bus into a MISR signature compared against an expected value.
module fuzz_sig_sched #(
  parameter int          IN_W      = 43,
  parameter int          Y_W       = 295,
  parameter int          SIG_W     = 32,
  parameter int          CNT_W     = 16,
  parameter int          WARM_CYC  = 4,
  parameter int          FLUSH_CYC = 3,
  parameter logic [63:0] DEF_SEED  = 64'h1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [63:0]      seed_i,
  input  logic [CNT_W-1:0] num_cycles_i,
  input  logic [SIG_W-1:0] exp_sig_i,
  input  logic [Y_W-1:0]   dut_y_i,
  output logic [IN_W-1:0]  stim_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [SIG_W-1:0] sig_o,
  output logic             match_o
);

  localparam int NSL = (Y_W + SIG_W - 1) / SIG_W;
  localparam logic [63:0]      LFSR_TAPS  = 64'hD800_0000_0000_0000;
  localparam logic [SIG_W-1:0] MISR_POLY  = SIG_W'(32'h04C1_1DB7);
  localparam logic [CNT_W-1:0] WARM_LAST  = CNT_W'((WARM_CYC > 0) ? WARM_CYC - 1 : 0);
  localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'((FLUSH_CYC > 0) ? FLUSH_CYC - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_WARM, S_RUN, S_FLUSH, S_DONE} state_t;

  localparam state_t POST_RUN = (FLUSH_CYC != 0) ? S_FLUSH : S_DONE;

  state_t             state, state_nxt;
  logic [63:0]        lfsr, lfsr_nxt;
  logic [SIG_W-1:0]   misr, misr_nxt, misr_fin, exp_fin, fold;
  logic [CNT_W-1:0]   cnt, num_q;
  logic [SIG_W-1:0]   exp_q;
  logic [NSL*SIG_W-1:0] ypad;
  logic               adv, start_acc, capture;

  always_comb begin
    ypad = '0;
    ypad[Y_W-1:0] = dut_y_i;
    fold = '0;
    for (int unsigned i = 0; i < NSL; i++) begin
      fold = fold ^ ypad[i*SIG_W +: SIG_W];
    end
    misr_nxt = (misr << 1) ^ (misr[SIG_W-1] ? MISR_POLY : '0) ^ fold;
    lfsr_nxt = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : '0);
  end

  assign capture = (state == S_RUN) || (state == S_FLUSH);

  // adv marks every state entry so the shared counter restarts at zero
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    start_acc = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          start_acc = 1'b1;
          adv       = 1'b1;
          if (WARM_CYC != 0)           state_nxt = S_WARM;
          else if (num_cycles_i != '0) state_nxt = S_RUN;
          else                         state_nxt = POST_RUN;
        end
      end
      S_WARM: begin
        if (cnt == WARM_LAST) begin
          adv       = 1'b1;
          state_nxt = (num_q != '0) ? S_RUN : POST_RUN;
        end
      end
      S_RUN: begin
        if (cnt == num_q - CNT_W'(1)) begin
          adv       = 1'b1;
          state_nxt = POST_RUN;
        end
      end
      S_FLUSH: begin
        if (cnt == FLUSH_LAST) begin
          adv       = 1'b1;
          state_nxt = S_DONE;
        end
      end
      default: begin
        adv       = 1'b1;
        state_nxt = S_IDLE;
      end
    endcase
    if (abort_i) begin
      state_nxt = S_IDLE;
      adv       = 1'b1;
      start_acc = 1'b0;
    end
  end

  // The final capture lands on the same edge that enters DONE, so sign off the next MISR value
  assign misr_fin = start_acc ? '0 : (capture ? misr_nxt : misr);
  assign exp_fin  = start_acc ? exp_sig_i : exp_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_IDLE;
      lfsr    <= '0;
      misr    <= '0;
      cnt     <= '0;
      num_q   <= '0;
      exp_q   <= '0;
      stim_o  <= '0;
      busy_o  <= 1'b0;
      done_o  <= 1'b0;
      sig_o   <= '0;
      match_o <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_o <= (state_nxt == S_WARM) || (state_nxt == S_RUN) || (state_nxt == S_FLUSH);
      done_o <= 1'b0;

      if (adv) cnt <= '0;
      else if (state != S_IDLE && state != S_DONE) cnt <= cnt + 1'b1;

      if (start_acc) begin
        num_q <= num_cycles_i;
        exp_q <= exp_sig_i;
        lfsr  <= (seed_i == '0) ? DEF_SEED : seed_i;
        misr  <= '0;
      end else begin
        if (state == S_WARM || state == S_RUN) begin
          stim_o <= lfsr[IN_W-1:0];
          lfsr   <= lfsr_nxt;
        end
        if (capture) misr <= misr_nxt;
      end

      if (abort_i) begin
        sig_o   <= '0;
        match_o <= 1'b0;
      end else if (adv && state_nxt == S_DONE) begin
        sig_o   <= misr_fin;
        match_o <= (misr_fin == exp_fin);
        done_o  <= 1'b1;
      end
    end
  end

endmodule
